// File: rtl/soc_system_ledr_sequencer.sv
// LEDR pattern sequencer: steps an 8-entry table onto the LEDR PIO
// with a programmable dwell, plus a prioritised direct-write path.
module soc_system_ledr_sequencer #(
   parameter int DWELL_W = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata
);

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      WAIT
   } state_t;

   state_t state;

   logic               en;
   logic               loop_r;
   logic [2:0]         last;
   logic [DWELL_W-1:0] dwell;
   logic [DWELL_W-1:0] cnt;
   logic [2:0]         idx;
   logic               done;
   logic [9:0]         direct;
   logic               dir_pend;
   logic [9:0]         pat [8];

   logic               wr;
   logic               ctrl_wr;
   logic               dwell_wr;
   logic               stat_wr;
   logic               dir_wr;
   logic               pat_wr;
   logic               stop;
   logic               seq_wr;
   logic               do_adv;
   logic [DWELL_W-1:0] dwell_eff;
   logic [DWELL_W-1:0] load;
   logic [2:0]         adv_idx;
   logic               adv_end;
   logic               unused_ok;

   assign wr        = s_chipselect && !s_write_n;
   assign ctrl_wr   = wr && (s_address == 4'd0);
   assign dwell_wr  = wr && (s_address == 4'd1);
   assign stat_wr   = wr && (s_address == 4'd2);
   assign dir_wr    = wr && (s_address == 4'd3);
   assign pat_wr    = wr && s_address[3];
   assign stop      = ctrl_wr && !s_writedata[0];

   assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign load      = dwell_eff - DWELL_W'(1);

   // A pending direct write steals the port; the STEP then holds.
   assign seq_wr    = (state == STEP) && !dir_pend && !stop;
   assign do_adv    = ((state == STEP) && !dir_pend && (load == '0))
                   || ((state == WAIT) && (cnt == DWELL_W'(1)));

   assign m_address = 2'b00;
   assign unused_ok = &{1'b0, s_writedata[31:10]};

   // End-of-list decision; IDX may exceed a live-updated LAST.
   always_comb begin
      adv_idx = idx;
      adv_end = 1'b0;
      if (idx < last) begin
         adv_idx = idx + 3'd1;
      end else if (loop_r) begin
         adv_idx = 3'd0;
      end else begin
         adv_end = 1'b1;
      end
   end

   // Config readback, zero wait states.
   always_comb begin
      s_readdata = '0;
      if (s_address[3]) begin
         s_readdata[9:0] = pat[s_address[2:0]];
      end else begin
         case (s_address[2:0])
            3'd0: s_readdata = {25'b0, last, 2'b0, loop_r, en};
            3'd1: s_readdata[DWELL_W-1:0] = dwell;
            3'd2: s_readdata = {23'b0, done, 1'b0, idx, 3'b0,
                                (state != IDLE)};
            3'd3: s_readdata[9:0] = direct;
            default: s_readdata = '0;
         endcase
      end
   end

   // Pattern table, dwell and direct-value registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dwell  <= DWELL_W'(1);
         direct <= '0;
         for (int i = 0; i < 8; i++) begin
            pat[i] <= '0;
         end
      end else begin
         if (dwell_wr) begin
            dwell <= s_writedata[DWELL_W-1:0];
         end
         if (dir_wr) begin
            direct <= s_writedata[9:0];
         end
         if (pat_wr) begin
            pat[s_address[2:0]] <= s_writedata[9:0];
         end
      end
   end

   // Sequencer FSM, control/status and the registered PIO master.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         en           <= 1'b0;
         loop_r       <= 1'b0;
         last         <= '0;
         idx          <= '0;
         cnt          <= '0;
         done         <= 1'b0;
         dir_pend     <= 1'b0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
      end else begin
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         if (dir_pend) begin
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= {22'b0, direct};
         end else if (seq_wr) begin
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= {22'b0, pat[idx]};
         end
         dir_pend <= dir_wr;

         if (stat_wr && s_writedata[8]) begin
            done <= 1'b0;
         end

         if ((state == STEP) && !dir_pend) begin
            cnt <= load;
         end else if (state == WAIT) begin
            cnt <= cnt - DWELL_W'(1);
         end

         if (stop) begin
            state <= IDLE;
            idx   <= '0;
         end else if (do_adv) begin
            if (adv_end) begin
               done  <= 1'b1;
               en    <= 1'b0;
               state <= IDLE;
            end else begin
               idx   <= adv_idx;
               state <= STEP;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  if (en) begin
                     state <= STEP;
                     idx   <= '0;
                     done  <= 1'b0;
                  end
               end
               STEP: begin
                  if (!dir_pend) begin
                     state <= WAIT;
                  end
               end
               WAIT: begin
               end
               default: state <= IDLE;
            endcase
         end

         if (ctrl_wr) begin
            en     <= s_writedata[0];
            loop_r <= s_writedata[1];
            last   <= s_writedata[6:4];
         end
      end
   end

endmodule

// File: tb/tb_soc_system_ledr_sequencer.sv
// Bench for soc_system_ledr_sequencer: schedule-based reference
// model feeding a scoreboard that a PIO monitor drains.
module tb_soc_system_ledr_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  s_address = '0;
   logic        s_chipselect = 1'b0;
   logic        s_write_n = 1'b1;
   logic [31:0] s_writedata = '0;
   logic [31:0] s_readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;

   typedef struct {
      int          t;
      logic [31:0] d;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   soc_system_ledr_sequencer #(.DWELL_W(24)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_address    (s_address),
      .s_chipselect (s_chipselect),
      .s_write_n    (s_write_n),
      .s_writedata  (s_writedata),
      .s_readdata   (s_readdata),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every PIO write must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (m_chipselect || !m_write_n) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL pio_unexpected: cycle %0d data %h, none expected",
                     cyc, m_writedata);
         end else begin
            e = q.pop_front();
            if (e.t != cyc || m_writedata !== e.d || m_chipselect !== 1'b1
                || m_write_n !== 1'b0 || m_address !== 2'b00) begin
               fails++;
               $display("FAIL pio_write: got cyc %0d data %h cs %b wn %b, want cyc %0d data %h",
                        cyc, m_writedata, m_chipselect, m_write_n, e.t, e.d);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // e = 0: as soon as possible, else sampled at edge e.
   task automatic cfg_wr(input int e, input logic [3:0] a,
                         input logic [31:0] d);
      @(negedge clk);
      while (e != 0 && cyc + 1 < e) @(negedge clk);
      s_address    = a;
      s_chipselect = 1'b1;
      s_write_n    = 1'b0;
      s_writedata  = d;
      @(posedge clk);
      #1;
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
   endtask

   task automatic cfg_rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      s_address    = a;
      s_chipselect = 1'b1;
      s_write_n    = 1'b1;
      #1;
      d = s_readdata;
      s_chipselect = 1'b0;
   endtask

   task automatic plan(output int n);
      @(negedge clk);
      n = cyc + 3;
   endtask

   task automatic push(input int t, input logic [31:0] d);
      q.push_back('{t: t, d: d & 32'h3FF});
   endtask

   task automatic drain(input string name, input int bound);
      int k = 0;
      while (q.size() != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(q.size()), 32'd0);
   endtask

   // One non-looping pass; mode 0 none, 1 colliding direct, 2 random offset.
   task automatic run_seq(input int d, input int l, input int mode,
                          input logic [31:0] dv);
      logic [31:0] p [8];
      int          t [8];
      int          de, n, m, dt;
      bit          shifted, dpushed;
      logic [31:0] rd;
      for (int i = 0; i < 8; i++) begin
         p[i] = $urandom;
         cfg_wr(0, 4'(8 + i), p[i]);
      end
      cfg_wr(0, 4'd1, 32'(d));
      de = (d == 0) ? 1 : d;
      plan(n);
      for (int k = 0; k <= l; k++) t[k] = n + 2 + k * de;
      dt = -1;
      m = 0;
      if (mode != 0) begin
         m = n + 1 + int'($urandom_range(0, l)) * de;
         if (mode == 2) m += int'($urandom_range(0, de - 1));
         dt = m + 1;
         shifted = 1'b0;
         for (int k = 0; k <= l; k++) begin
            if (t[k] == dt) shifted = 1'b1;
            if (shifted) t[k]++;
         end
      end
      dpushed = (mode == 0);
      for (int k = 0; k <= l; k++) begin
         if (!dpushed && t[k] > dt) begin
            push(dt, dv);
            dpushed = 1'b1;
         end
         push(t[k], p[k]);
      end
      if (!dpushed) push(dt, dv);
      cfg_wr(n, 4'd0, 32'(l << 4) | 32'h1);
      if (mode != 0) cfg_wr(m, 4'd3, dv);
      drain("seq_drain", (l + 2) * (de + 2) + 20);
      repeat (de + 3) @(negedge clk);
      cfg_rd(4'd2, rd);
      check("seq_done_running", rd & 32'h101, 32'h100);
      cfg_rd(4'd0, rd);
      check("seq_ctrl_en_cleared", rd, 32'(l << 4));
      if (mode != 0) begin
         cfg_rd(4'd3, rd);
         check("direct_readback", rd, dv & 32'h3FF);
      end
      cfg_wr(0, 4'd2, 32'h100);
      cfg_rd(4'd2, rd);
      check("done_clear", rd & 32'h100, 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] p0, p1;
      int          n, e, w;

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      check("rst_cs", 32'(m_chipselect), 32'h0);
      check("rst_wn", 32'(m_write_n), 32'h1);
      check("rst_wd", m_writedata, 32'h0);
      cfg_rd(4'd2, rd);
      check("rst_status", rd, 32'h0);
      cfg_rd(4'd1, rd);
      check("rst_dwell", rd, 32'h1);
      cfg_rd(4'd0, rd);
      check("rst_ctrl", rd, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Register readback and masking.
      cfg_wr(0, 4'd15, 32'hFFFF_FFFF);
      cfg_rd(4'd15, rd);
      check("pat7_mask", rd, 32'h3FF);
      cfg_wr(0, 4'd5, 32'hDEAD_BEEF);
      cfg_rd(4'd5, rd);
      check("reserved_5", rd, 32'h0);
      cfg_wr(0, 4'd1, 32'hA5A5_A5A5);
      cfg_rd(4'd1, rd);
      check("dwell_mask", rd, 32'h00A5_A5A5);

      // Single pass, DWELL=4, LAST=2.
      run_seq(4, 2, 0, 32'h0);

      // Loop with DWELL=0, then stop with EN=0.
      p0 = $urandom;
      p1 = $urandom;
      cfg_wr(0, 4'd8, p0);
      cfg_wr(0, 4'd9, p1);
      cfg_wr(0, 4'd1, 32'h0);
      plan(n);
      w = int'($urandom_range(2, 10));
      e = n + 2 + w;
      for (int t = n + 2; t < e; t++) push(t, ((t - n) % 2 == 0) ? p0 : p1);
      cfg_wr(n, 4'd0, 32'h13);
      cfg_wr(e, 4'd0, 32'h12);
      repeat (3) @(negedge clk);
      check("loop_drain", 32'(q.size()), 32'h0);
      cfg_rd(4'd2, rd);
      check("loop_stop_status", rd, 32'h0);

      // Directed collision of DIRECT 0x155 with a STEP.
      run_seq(3, 3, 1, 32'h155);

      // Randomised passes.
      for (int i = 0; i < 10; i++) begin
         run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 2)), $urandom);
      end

      // Reset in the middle of a WAIT.
      p0 = $urandom;
      cfg_wr(0, 4'd8, p0);
      cfg_wr(0, 4'd1, 32'd20);
      plan(n);
      push(n + 2, p0);
      cfg_wr(n, 4'd0, 32'h73);
      while (cyc < n + 8) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_cs", 32'(m_chipselect), 32'h0);
      check("midrst_wn", 32'(m_write_n), 32'h1);
      check("midrst_wd", m_writedata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check("midrst_drain", 32'(q.size()), 32'h0);
      cfg_rd(4'd2, rd);
      check("midrst_status", rd, 32'h0);
      cfg_rd(4'd0, rd);
      check("midrst_ctrl", rd, 32'h0);
      cfg_rd(4'd1, rd);
      check("midrst_dwell", rd, 32'h1);
      cfg_rd(4'd8, rd);
      check("midrst_pat0", rd, 32'h0);

      // Restart after reset.
      run_seq(2, 4, 2, $urandom);

      repeat (5) @(negedge clk);
      check("final_queue", 32'(q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
